// File: rtl/lcd_pkg.sv
// Shared constants, timing defaults and state encodings for the LCD
// DDRAM read-back sequencer and its bus-cycle engine.
package lcd_pkg;

  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam int         BF_BIT        = 7;
  localparam logic [4:0] MAX_LEN       = 5'd16;

  localparam int DEF_SETUP_CYC  = 4;
  localparam int DEF_EN_CYC     = 16;
  localparam int DEF_HOLD_CYC   = 4;
  localparam int DEF_BF_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BF_POLL,
    ST_SETADDR,
    ST_RDDATA,
    ST_DONE,
    ST_ERR
  } rd_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_EN,
    PH_HOLD
  } phase_t;

endpackage

// File: rtl/lcd_bus_cycle.sv
// Executes one LCD bus access (setup / enable / hold) and owns every LCD pin
// except the read data input. Read data is captured on the last EN=1 cycle.
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int EN_CYC    = DEF_EN_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iGO,
  input  logic       iRS,
  input  logic       iRW,
  input  logic [7:0] iWDATA,
  output logic [7:0] oRDATA,
  output logic       oHOLD_START,
  output logic       oDONE,
  input  logic [7:0] LCD_DATA_IN,
  output logic [7:0] LCD_DATA_OUT,
  output logic       LCD_DATA_OE,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_EN
);

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] EN_LAST    = 8'(EN_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);

  phase_t     phase;
  logic [7:0] cnt;

  // RS/RW/DATA_OUT are only loaded on acceptance of a request, so they stay
  // stable across the whole access; OE drops once the hold phase finishes.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      phase        <= PH_IDLE;
      cnt          <= '0;
      oRDATA       <= '0;
      oHOLD_START  <= 1'b0;
      oDONE        <= 1'b0;
      LCD_DATA_OUT <= '0;
      LCD_DATA_OE  <= 1'b0;
      LCD_RW       <= 1'b0;
      LCD_RS       <= 1'b0;
      LCD_EN       <= 1'b0;
    end else begin
      oHOLD_START <= 1'b0;
      oDONE       <= 1'b0;
      case (phase)
        PH_IDLE: begin
          if (iGO) begin
            LCD_RS       <= iRS;
            LCD_RW       <= iRW;
            LCD_DATA_OE  <= ~iRW;
            LCD_DATA_OUT <= iWDATA;
            cnt          <= '0;
            phase        <= PH_SETUP;
          end
        end
        PH_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt    <= '0;
            LCD_EN <= 1'b1;
            phase  <= PH_EN;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        PH_EN: begin
          if (cnt == EN_LAST) begin
            cnt         <= '0;
            LCD_EN      <= 1'b0;
            oRDATA      <= LCD_DATA_IN;
            oHOLD_START <= 1'b1;
            phase       <= PH_HOLD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        PH_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt         <= '0;
            LCD_DATA_OE <= 1'b0;
            oDONE       <= 1'b1;
            phase       <= PH_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_readback_fsm.sv
// Reads iLEN bytes back from HD44780 DDRAM: BF poll, set address, then
// (BF poll, data read) per byte, streaming each byte to the host.
module lcd_readback_fsm
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int EN_CYC     = DEF_EN_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int BF_TIMEOUT = DEF_BF_TIMEOUT
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iSTART,
  input  logic [6:0] iADDR,
  input  logic [4:0] iLEN,
  output logic [7:0] oDATA,
  output logic       oVALID,
  output logic       oDONE,
  output logic       oERR,
  output logic       oBUSY,
  output logic [6:0] oADDR_COUNTER,
  input  logic [7:0] LCD_DATA_IN,
  output logic [7:0] LCD_DATA_OUT,
  output logic       LCD_DATA_OE,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_EN
);

  localparam int              PW         = $clog2(BF_TIMEOUT + 1);
  localparam logic [PW-1:0]   POLL_LIMIT = PW'(BF_TIMEOUT);

  rd_state_t     state;
  rd_state_t     ret_state;
  logic [6:0]    addr;
  logic [4:0]    remaining;
  logic [PW-1:0] poll_cnt;
  logic [4:0]    len_clamped;

  logic          go;
  logic          bus_rs;
  logic          bus_rw;
  logic [7:0]    bus_wdata;
  logic [7:0]    bus_rdata;
  logic          bus_hold_start;
  logic          bus_done;

  assign len_clamped = (iLEN > MAX_LEN) ? MAX_LEN : iLEN;

  lcd_bus_cycle #(
    .SETUP_CYC (SETUP_CYC),
    .EN_CYC    (EN_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_bus (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iGO          (go),
    .iRS          (bus_rs),
    .iRW          (bus_rw),
    .iWDATA       (bus_wdata),
    .oRDATA       (bus_rdata),
    .oHOLD_START  (bus_hold_start),
    .oDONE        (bus_done),
    .LCD_DATA_IN  (LCD_DATA_IN),
    .LCD_DATA_OUT (LCD_DATA_OUT),
    .LCD_DATA_OE  (LCD_DATA_OE),
    .LCD_RW       (LCD_RW),
    .LCD_RS       (LCD_RS),
    .LCD_EN       (LCD_EN)
  );

  // Each bus-owning state launches its access with a one-cycle go pulse on
  // entry and then waits for the engine's done strobe.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state         <= ST_IDLE;
      ret_state     <= ST_SETADDR;
      addr          <= '0;
      remaining     <= '0;
      poll_cnt      <= '0;
      go            <= 1'b0;
      bus_rs        <= 1'b0;
      bus_rw        <= 1'b0;
      bus_wdata     <= '0;
      oDATA         <= '0;
      oVALID        <= 1'b0;
      oDONE         <= 1'b0;
      oERR          <= 1'b0;
      oBUSY         <= 1'b0;
      oADDR_COUNTER <= '0;
    end else begin
      go     <= 1'b0;
      oVALID <= 1'b0;
      oDONE  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iSTART) begin
            oERR      <= 1'b0;
            addr      <= iADDR;
            remaining <= len_clamped;
            if (len_clamped == 5'd0) begin
              oDONE <= 1'b1;
            end else begin
              oBUSY     <= 1'b1;
              state     <= ST_BF_POLL;
              ret_state <= ST_SETADDR;
              go        <= 1'b1;
              bus_rs    <= 1'b0;
              bus_rw    <= 1'b1;
              bus_wdata <= '0;
            end
          end
        end
        ST_BF_POLL: begin
          if (bus_done) begin
            oADDR_COUNTER <= bus_rdata[6:0];
            if (!bus_rdata[BF_BIT]) begin
              poll_cnt <= '0;
              state    <= ret_state;
              go       <= 1'b1;
              if (ret_state == ST_SETADDR) begin
                bus_rs    <= 1'b0;
                bus_rw    <= 1'b0;
                bus_wdata <= CMD_SET_DDRAM | {1'b0, addr};
              end else begin
                bus_rs    <= 1'b1;
                bus_rw    <= 1'b1;
                bus_wdata <= '0;
              end
            end else if (poll_cnt + 1'b1 == POLL_LIMIT) begin
              poll_cnt <= '0;
              state    <= ST_ERR;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
              go       <= 1'b1;
            end
          end
        end
        ST_SETADDR: begin
          if (bus_done) begin
            state     <= ST_BF_POLL;
            ret_state <= ST_RDDATA;
            go        <= 1'b1;
            bus_rs    <= 1'b0;
            bus_rw    <= 1'b1;
            bus_wdata <= '0;
          end
        end
        ST_RDDATA: begin
          if (bus_hold_start) begin
            oDATA  <= bus_rdata;
            oVALID <= 1'b1;
          end
          if (bus_done) begin
            remaining <= remaining - 1'b1;
            if (remaining == 5'd1) begin
              state <= ST_DONE;
            end else begin
              state     <= ST_BF_POLL;
              ret_state <= ST_RDDATA;
              go        <= 1'b1;
              bus_rs    <= 1'b0;
              bus_rw    <= 1'b1;
              bus_wdata <= '0;
            end
          end
        end
        ST_DONE: begin
          oDONE <= 1'b1;
          oBUSY <= 1'b0;
          state <= ST_IDLE;
        end
        ST_ERR: begin
          oERR  <= 1'b1;
          oDONE <= 1'b1;
          oBUSY <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_readback_fsm.sv
// Self-checking bench for lcd_readback_fsm: a behavioural HD44780 model on
// the bus plus a host-side monitor, compared against spec-level expectations.
module tb_lcd_readback_fsm;

  localparam int CLK_HALF = 5;
  localparam int EN_CYC   = 16;
  localparam int TIMEOUT  = 8;

  logic       iCLK   = 1'b0;
  logic       iRST   = 1'b1;
  logic       iSTART = 1'b0;
  logic [6:0] iADDR  = '0;
  logic [4:0] iLEN   = '0;
  logic [7:0] oDATA;
  logic       oVALID, oDONE, oERR, oBUSY;
  logic [6:0] oADDR_COUNTER;
  logic [7:0] LCD_DATA_IN = '0;
  logic [7:0] LCD_DATA_OUT;
  logic       LCD_DATA_OE, LCD_RW, LCD_RS, LCD_EN;

  int checks = 0;
  int errors = 0;

  always #CLK_HALF iCLK = ~iCLK;

  lcd_readback_fsm #(
    .BF_TIMEOUT (TIMEOUT)
  ) dut (
    .iCLK          (iCLK),
    .iRST          (iRST),
    .iSTART        (iSTART),
    .iADDR         (iADDR),
    .iLEN          (iLEN),
    .oDATA         (oDATA),
    .oVALID        (oVALID),
    .oDONE         (oDONE),
    .oERR          (oERR),
    .oBUSY         (oBUSY),
    .oADDR_COUNTER (oADDR_COUNTER),
    .LCD_DATA_IN   (LCD_DATA_IN),
    .LCD_DATA_OUT  (LCD_DATA_OUT),
    .LCD_DATA_OE   (LCD_DATA_OE),
    .LCD_RW        (LCD_RW),
    .LCD_RS        (LCD_RS),
    .LCD_EN        (LCD_EN)
  );

  // LCD controller model: answers each access when EN rises and logs it.
  typedef struct {
    logic       rs;
    logic       rw;
    logic [7:0] data;
    logic       bf;
    logic [6:0] ac_seen;
  } acc_t;

  acc_t       acc_log[$];
  logic [7:0] ddram [128];
  logic [6:0] ac          = '0;
  int         busy_left   = 0;
  int         busy_reload = 0;
  bit         bf_stuck    = 1'b0;
  int         preset_gen  = 0;
  int         preset_seen = 0;
  logic [6:0] ac_preset   = '0;
  int         busy_preset = 0;
  int         en_rises    = 0;
  int         en_bad      = 0;
  time        t_rise      = 0;

  always @(posedge LCD_EN) begin : lcd_model
    acc_t a;
    if (preset_gen != preset_seen) begin
      ac          = ac_preset;
      busy_left   = busy_preset;
      preset_seen = preset_gen;
    end
    a.rs      = LCD_RS;
    a.rw      = LCD_RW;
    a.data    = LCD_DATA_OUT;
    a.bf      = 1'b0;
    a.ac_seen = oADDR_COUNTER;
    if (!LCD_RS && LCD_RW) begin
      if (bf_stuck || busy_left > 0) begin
        a.bf = 1'b1;
        if (busy_left > 0) busy_left = busy_left - 1;
      end else begin
        busy_left = $urandom_range(0, busy_reload);
      end
      LCD_DATA_IN = {a.bf, ac};
    end else if (LCD_RS && LCD_RW) begin
      LCD_DATA_IN = ddram[ac];
      a.data      = ddram[ac];
      ac          = ac + 7'd1;
    end else if (!LCD_RS && LCD_DATA_OUT[7]) begin
      ac = LCD_DATA_OUT[6:0];
    end
    acc_log.push_back(a);
    en_rises = en_rises + 1;
    t_rise   = $time;
  end

  always @(negedge LCD_EN) begin
    if (!iRST && ($time - t_rise) != time'(EN_CYC * 2 * CLK_HALF)) begin
      en_bad = en_bad + 1;
    end
  end

  // Host-side monitor.
  logic [7:0] rx_q[$];
  int         done_cnt      = 0;
  logic       last_done_err = 1'b0;

  always @(negedge iCLK) begin
    if (oVALID) rx_q.push_back(oDATA);
    if (oDONE) begin
      done_cnt      = done_cnt + 1;
      last_done_err = oERR;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic string access_string(int base, bit keep_busy);
    string s;
    s = "";
    for (int i = base; i < acc_log.size(); i++) begin
      if (!acc_log[i].rs && acc_log[i].rw) begin
        if (!acc_log[i].bf) s = {s, "B"};
        else if (keep_busy) s = {s, "b"};
      end else if (!acc_log[i].rs) begin
        s = {s, "W"};
      end else if (acc_log[i].rw) begin
        s = {s, "R"};
      end else begin
        s = {s, "X"};
      end
    end
    return s;
  endfunction

  function automatic string expect_seq(int n);
    string s;
    s = "";
    if (n > 0) begin
      s = "BW";
      for (int i = 0; i < n; i++) s = {s, "BR"};
    end
    return s;
  endfunction

  function automatic int clamp_len(int len);
    return (len > 16) ? 16 : len;
  endfunction

  task automatic set_preset(input logic [6:0] a, input int busy);
    ac_preset   = a;
    busy_preset = busy;
    preset_gen  = preset_gen + 1;
  endtask

  task automatic fill_ddram();
    for (int i = 0; i < 128; i++) ddram[i] = 8'($urandom);
  endtask

  task automatic apply_start(input logic [6:0] a, input logic [4:0] len);
    @(negedge iCLK);
    iSTART = 1'b1;
    iADDR  = a;
    iLEN   = len;
    @(negedge iCLK);
    iSTART = 1'b0;
    #1;
  endtask

  task automatic wait_done(input int prev, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge iCLK);
      #1;
      if (done_cnt > prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge iCLK);
    checks++; if (oDATA !== 8'h00) begin errors++; $display("[TB] FAIL reset_oDATA: got %h expected 00", oDATA); end
    checks++; if (oVALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_oVALID: got %b expected 0", oVALID); end
    checks++; if (oDONE !== 1'b0) begin errors++; $display("[TB] FAIL reset_oDONE: got %b expected 0", oDONE); end
    checks++; if (oERR !== 1'b0) begin errors++; $display("[TB] FAIL reset_oERR: got %b expected 0", oERR); end
    checks++; if (oBUSY !== 1'b0) begin errors++; $display("[TB] FAIL reset_oBUSY: got %b expected 0", oBUSY); end
    checks++; if (oADDR_COUNTER !== 7'h00) begin errors++; $display("[TB] FAIL reset_oADDR_COUNTER: got %h expected 00", oADDR_COUNTER); end
    checks++; if (LCD_DATA_OUT !== 8'h00) begin errors++; $display("[TB] FAIL reset_LCD_DATA_OUT: got %h expected 00", LCD_DATA_OUT); end
    checks++; if ({LCD_DATA_OE, LCD_RW, LCD_RS, LCD_EN} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_lcd_ctrl: got %b expected 0000", {LCD_DATA_OE, LCD_RW, LCD_RS, LCD_EN});
    end
    iRST = 1'b0;
    repeat (50) @(negedge iCLK);
    checks++; if (en_rises != 0) begin errors++; $display("[TB] FAIL idle_en_pulses: got %0d expected 0", en_rises); end
    checks++; if (oBUSY !== 1'b0) begin errors++; $display("[TB] FAIL idle_oBUSY: got %b expected 0", oBUSY); end
  endtask

  task automatic test_nominal();
    int base, rbase, prev, bad0;
    bit ok;
    string got;
    logic [7:0] wd;
    ddram[7'h40] = 8'h41;
    ddram[7'h41] = 8'h42;
    busy_reload = 0;
    bf_stuck    = 1'b0;
    set_preset(7'h00, 0);
    base = acc_log.size(); rbase = rx_q.size(); prev = done_cnt; bad0 = en_bad;
    apply_start(7'h40, 5'd2);
    checks++; if (oBUSY !== 1'b1) begin errors++; $display("[TB] FAIL nominal_busy: got %b expected 1", oBUSY); end
    wait_done(prev, 5000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL nominal_done_wait: got timeout expected oDONE"); end
    repeat (5) @(negedge iCLK);
    got = access_string(base, 1'b1);
    checks++; if (got != "BWBRBR") begin errors++; $display("[TB] FAIL nominal_seq: got %s expected BWBRBR", got); end
    wd = (acc_log.size() > base + 1) ? acc_log[base + 1].data : 8'hxx;
    checks++; if (wd !== 8'hC0) begin errors++; $display("[TB] FAIL nominal_cmd: got %h expected c0", wd); end
    checks++; if (rx_q.size() - rbase != 2) begin errors++; $display("[TB] FAIL nominal_count: got %0d expected 2", rx_q.size() - rbase); end
    if (rx_q.size() - rbase >= 2) begin
      checks++; if (rx_q[rbase] !== 8'h41) begin errors++; $display("[TB] FAIL nominal_byte0: got %h expected 41", rx_q[rbase]); end
      checks++; if (rx_q[rbase + 1] !== 8'h42) begin errors++; $display("[TB] FAIL nominal_byte1: got %h expected 42", rx_q[rbase + 1]); end
    end
    checks++; if (done_cnt != prev + 1) begin errors++; $display("[TB] FAIL nominal_done_count: got %0d expected %0d", done_cnt - prev, 1); end
    checks++; if (last_done_err !== 1'b0) begin errors++; $display("[TB] FAIL nominal_err: got %b expected 0", last_done_err); end
    checks++; if (en_bad != bad0) begin errors++; $display("[TB] FAIL nominal_en_width: got %0d bad pulses expected 0", en_bad - bad0); end
  endtask

  task automatic test_busy_wait();
    int base, rbase, prev;
    bit ok;
    string got;
    logic [6:0] seen;
    fill_ddram();
    busy_reload = 0;
    set_preset(7'h05, 3);
    base = acc_log.size(); rbase = rx_q.size(); prev = done_cnt;
    apply_start(7'h10, 5'd1);
    wait_done(prev, 5000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL busy_done_wait: got timeout expected oDONE"); end
    got = access_string(base, 1'b1);
    checks++; if (got != "bbbBWBR") begin errors++; $display("[TB] FAIL busy_seq: got %s expected bbbBWBR", got); end
    seen = (acc_log.size() > base + 4) ? acc_log[base + 4].ac_seen : 7'hxx;
    checks++; if (seen !== 7'h05) begin errors++; $display("[TB] FAIL busy_addr_counter: got %h expected 05", seen); end
    checks++; if (rx_q.size() - rbase != 1 || rx_q[rbase] !== ddram[7'h10]) begin
      errors++; $display("[TB] FAIL busy_data: got %0d bytes expected 1 byte %h", rx_q.size() - rbase, ddram[7'h10]);
    end
  endtask

  task automatic test_timeout();
    int base, rbase, prev;
    bit ok;
    string got;
    bf_stuck = 1'b1;
    base = acc_log.size(); rbase = rx_q.size(); prev = done_cnt;
    apply_start(7'h20, 5'd3);
    wait_done(prev, 5000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL timeout_done_wait: got timeout expected oDONE"); end
    checks++; if (last_done_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err_with_done: got %b expected 1", last_done_err); end
    repeat (5) @(negedge iCLK);
    got = access_string(base, 1'b1);
    checks++; if (got != "bbbbbbbb") begin errors++; $display("[TB] FAIL timeout_seq: got %s expected bbbbbbbb", got); end
    checks++; if (oERR !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err_held: got %b expected 1", oERR); end
    checks++; if (rx_q.size() != rbase) begin errors++; $display("[TB] FAIL timeout_no_data: got %0d bytes expected 0", rx_q.size() - rbase); end
    bf_stuck = 1'b0;
  endtask

  task automatic test_len_zero();
    int prev, r0;
    prev = done_cnt; r0 = en_rises;
    apply_start(7'h11, 5'd0);
    checks++; if (oDONE !== 1'b1) begin errors++; $display("[TB] FAIL len0_done: got %b expected 1", oDONE); end
    @(negedge iCLK); #1;
    checks++; if (oDONE !== 1'b0) begin errors++; $display("[TB] FAIL len0_done_pulse: got %b expected 0", oDONE); end
    repeat (40) @(negedge iCLK);
    checks++; if (en_rises != r0) begin errors++; $display("[TB] FAIL len0_no_bus: got %0d pulses expected 0", en_rises - r0); end
    checks++; if (done_cnt != prev + 1) begin errors++; $display("[TB] FAIL len0_done_count: got %0d expected 1", done_cnt - prev); end
  endtask

  task automatic test_clamp();
    int base, rbase, prev;
    bit ok;
    string got, exp;
    logic [6:0] a;
    logic [7:0] b;
    fill_ddram();
    busy_reload = 1;
    set_preset(7'h00, 0);
    a = 7'($urandom);
    base = acc_log.size(); rbase = rx_q.size(); prev = done_cnt;
    apply_start(a, 5'd20);
    checks++; if (oERR !== 1'b0) begin errors++; $display("[TB] FAIL clamp_err_cleared: got %b expected 0", oERR); end
    wait_done(prev, 8000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL clamp_done_wait: got timeout expected oDONE"); end
    checks++; if (rx_q.size() - rbase != 16) begin errors++; $display("[TB] FAIL clamp_count: got %0d expected 16", rx_q.size() - rbase); end
    for (int i = 0; i < 16; i++) begin
      b = (rbase + i < rx_q.size()) ? rx_q[rbase + i] : 8'hxx;
      checks++; if (b !== ddram[(int'(a) + i) % 128]) begin
        errors++; $display("[TB] FAIL clamp_byte%0d: got %h expected %h", i, b, ddram[(int'(a) + i) % 128]);
      end
    end
    got = access_string(base, 1'b0);
    exp = expect_seq(16);
    checks++; if (got != exp) begin errors++; $display("[TB] FAIL clamp_seq: got %s expected %s", got, exp); end
  endtask

  task automatic test_ignore_start();
    int base, rbase, prev, r0;
    bit ok;
    string got, exp;
    logic [7:0] wd;
    fill_ddram();
    busy_reload = 0;
    set_preset(7'h00, 0);
    base = acc_log.size(); rbase = rx_q.size(); prev = done_cnt;
    apply_start(7'h2A, 5'd2);
    repeat (40) @(negedge iCLK);
    iSTART = 1'b1; iADDR = 7'h55; iLEN = 5'd5;
    @(negedge iCLK);
    iSTART = 1'b0;
    wait_done(prev, 5000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ignore_done_wait: got timeout expected oDONE"); end
    r0 = en_rises;
    repeat (80) @(negedge iCLK);
    got = access_string(base, 1'b1);
    exp = expect_seq(2);
    checks++; if (got != exp) begin errors++; $display("[TB] FAIL ignore_seq: got %s expected %s", got, exp); end
    wd = (acc_log.size() > base + 1) ? acc_log[base + 1].data : 8'hxx;
    checks++; if (wd !== 8'hAA) begin errors++; $display("[TB] FAIL ignore_cmd: got %h expected aa", wd); end
    checks++; if (rx_q.size() - rbase != 2) begin errors++; $display("[TB] FAIL ignore_count: got %0d expected 2", rx_q.size() - rbase); end
    checks++; if (done_cnt != prev + 1 || en_rises != r0) begin
      errors++; $display("[TB] FAIL ignore_no_second: got %0d done %0d extra pulses expected 1 done 0 pulses", done_cnt - prev, en_rises - r0);
    end
  endtask

  task automatic test_back_to_back();
    int base, rbase, prev, n, len, bad0, mism;
    bit ok;
    string got, exp;
    logic [6:0] a;
    bad0 = en_bad;
    for (int t = 0; t < 6; t++) begin
      fill_ddram();
      busy_reload = $urandom_range(0, 2);
      set_preset(7'($urandom), $urandom_range(0, 3));
      a   = 7'($urandom);
      len = $urandom_range(0, 31);
      n   = clamp_len(len);
      base = acc_log.size(); rbase = rx_q.size(); prev = done_cnt;
      apply_start(a, 5'(len));
      wait_done(prev, 8000, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b%0d_done_wait: got timeout expected oDONE", t); end
      checks++; if (last_done_err !== 1'b0) begin errors++; $display("[TB] FAIL b2b%0d_err: got %b expected 0", t, last_done_err); end
      got = access_string(base, 1'b0);
      exp = expect_seq(n);
      checks++; if (got != exp) begin errors++; $display("[TB] FAIL b2b%0d_seq: got %s expected %s", t, got, exp); end
      checks++; if (rx_q.size() - rbase != n) begin errors++; $display("[TB] FAIL b2b%0d_count: got %0d expected %0d", t, rx_q.size() - rbase, n); end
      mism = 0;
      for (int i = 0; i < n && rbase + i < rx_q.size(); i++) begin
        if (rx_q[rbase + i] !== ddram[(int'(a) + i) % 128]) mism++;
      end
      checks++; if (mism != 0) begin errors++; $display("[TB] FAIL b2b%0d_data: got %0d wrong bytes expected 0", t, mism); end
    end
    checks++; if (en_bad != bad0) begin errors++; $display("[TB] FAIL b2b_en_width: got %0d bad pulses expected 0", en_bad - bad0); end
  endtask

  task automatic test_reset_mid_en();
    int prev, r0;
    bit found;
    busy_reload = 0;
    set_preset(7'h00, 0);
    prev = done_cnt;
    apply_start(7'h33, 5'd4);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge iCLK);
      if (LCD_EN === 1'b1 && LCD_RW === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL rstmid_write_en: got none expected write access"); end
    #2;
    checks++; if (LCD_DATA_OE !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_oe_write: got %b expected 1", LCD_DATA_OE); end
    iRST = 1'b1;
    #1;
    checks++; if (LCD_EN !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_en: got %b expected 0", LCD_EN); end
    checks++; if (LCD_DATA_OE !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_oe: got %b expected 0", LCD_DATA_OE); end
    repeat (3) @(negedge iCLK);
    iRST = 1'b0;
    r0 = en_rises;
    repeat (60) @(negedge iCLK);
    checks++; if (done_cnt != prev) begin errors++; $display("[TB] FAIL rstmid_no_done: got %0d expected 0", done_cnt - prev); end
    checks++; if (oBUSY !== 1'b0 || en_rises != r0) begin
      errors++; $display("[TB] FAIL rstmid_idle: got busy %b pulses %0d expected busy 0 pulses 0", oBUSY, en_rises - r0);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_nominal();
    test_busy_wait();
    test_timeout();
    test_len_zero();
    test_clamp();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_en();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
